// File: rtl/io_unit_pkg.sv
// Shared types, IO memory map and address decode for the IO unit.
// The map offsets live here only; the decode function is the single consumer.
package io_unit_pkg;

   localparam logic [27:0] PHY_ADDR_TIMER_MTIME_LO = 28'h000_0000;
   localparam logic [27:0] PHY_ADDR_TIMER_MTIME_HI = 28'h000_0004;
   localparam logic [27:0] PHY_ADDR_TIMER_CMP_LO   = 28'h000_0008;
   localparam logic [27:0] PHY_ADDR_TIMER_CMP_HI   = 28'h000_000C;
   localparam logic [27:0] PHY_ADDR_SERIAL_OUTPUT  = 28'h000_2000;

   typedef struct packed {
      logic        isUncachable;
      logic        isIO;
      logic [27:0] addr;
   } PhyAddrPath;

   typedef enum logic [2:0] {
      IRS_MTIME_LO,
      IRS_MTIME_HI,
      IRS_CMP_LO,
      IRS_CMP_HI,
      IRS_SERIAL,
      IRS_NONE
   } IoRegSel;

   typedef struct packed {
      logic        write;
      PhyAddrPath  addr;
      logic [31:0] wdata;
   } IoReq;

   typedef struct packed {
      logic        error;
      logic [31:0] rdata;
   } IoRsp;

   // Only word-aligned accesses flagged as IO reach a register; all else faults.
   function automatic IoRegSel DecodeIoAddr(input logic isIO, input logic [27:0] addr);
      IoRegSel sel;
      sel = IRS_NONE;
      if (isIO && (addr[1:0] == 2'b00)) begin
         case (addr)
            PHY_ADDR_TIMER_MTIME_LO: sel = IRS_MTIME_LO;
            PHY_ADDR_TIMER_MTIME_HI: sel = IRS_MTIME_HI;
            PHY_ADDR_TIMER_CMP_LO:   sel = IRS_CMP_LO;
            PHY_ADDR_TIMER_CMP_HI:   sel = IRS_CMP_HI;
            PHY_ADDR_SERIAL_OUTPUT:  sel = IRS_SERIAL;
            default:                 sel = IRS_NONE;
         endcase
      end
      return sel;
   endfunction

endpackage

// File: rtl/io_unit_serial_tx_fifo.sv
// Serial TX byte buffer: power-of-two depth, pointers carry an extra wrap bit
// so full and empty are distinguishable without a separate count.
module io_unit_serial_tx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic             do_push, do_pop;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign wptr_d  = do_push ? wptr_q + PTR_ONE : wptr_q;
   assign rptr_d  = do_pop ? rptr_q + PTR_ONE : rptr_q;
   assign head_o  = mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage needs no reset: pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/io_unit.sv
// IO unit: decodes physical IO requests, hosts the mtime/mtimecmp timer and
// a buffered serial output; one registered response per accepted request.
module io_unit
   import io_unit_pkg::*;
#(
   parameter int SERIAL_FIFO_DEPTH = 8,
   parameter int TIMER_PRESCALE    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ioReqValid,
   output logic        ioReqReady,
   input  logic        ioReqWrite,
   input  logic [29:0] ioReqAddr,
   input  logic [31:0] ioReqWData,
   output logic        ioRspValid,
   output logic [31:0] ioRspRData,
   output logic        ioRspError,
   output logic        timerIrq,
   output logic        serialValid,
   output logic [7:0]  serialData,
   input  logic        serialReady
);

   localparam int PW = (TIMER_PRESCALE > 1) ? $clog2(TIMER_PRESCALE) : 1;

   PhyAddrPath    pa;
   IoRegSel       sel;
   logic          fifo_full, fifo_empty;
   logic          accept, wr_en, push, pop, tick;
   logic          rsp_valid_q;
   IoRsp          rsp_q, rsp_d;
   logic [63:0]   mtime_q, mtime_d;
   logic [63:0]   cmp_q, cmp_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          irq_q;
   logic          unused_uncachable;

   assign pa                = ioReqAddr;
   assign unused_uncachable = pa.isUncachable;
   assign sel               = DecodeIoAddr(pa.isIO, pa.addr);

   // A full FIFO stalls serial writes instead of faulting them.
   assign ioReqReady = !rsp_valid_q && !(ioReqWrite && (sel == IRS_SERIAL) && fifo_full);
   assign accept     = ioReqValid && ioReqReady;
   assign wr_en      = accept && ioReqWrite;
   assign push       = wr_en && (sel == IRS_SERIAL);
   assign pop        = !fifo_empty && serialReady;

   always_comb begin
      rsp_d       = '0;
      rsp_d.error = (sel == IRS_NONE);
      if (!ioReqWrite) begin
         case (sel)
            IRS_MTIME_LO: rsp_d.rdata = mtime_q[31:0];
            IRS_MTIME_HI: rsp_d.rdata = mtime_q[63:32];
            IRS_CMP_LO:   rsp_d.rdata = cmp_q[31:0];
            IRS_CMP_HI:   rsp_d.rdata = cmp_q[63:32];
            IRS_SERIAL:   rsp_d.rdata = {30'b0, fifo_full, fifo_empty};
            default:      rsp_d.rdata = '0;
         endcase
      end
   end

   assign tick = (presc_q == PW'(TIMER_PRESCALE - 1));

   // Increment first, then a software write overrides only the word it targets.
   always_comb begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
      cmp_d   = cmp_q;
      if (wr_en) begin
         case (sel)
            IRS_MTIME_LO: mtime_d[31:0]  = ioReqWData;
            IRS_MTIME_HI: mtime_d[63:32] = ioReqWData;
            IRS_CMP_LO:   cmp_d[31:0]    = ioReqWData;
            IRS_CMP_HI:   cmp_d[63:32]   = ioReqWData;
            default:      cmp_d          = cmp_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid_q <= 1'b0;
         rsp_q       <= '0;
         mtime_q     <= '0;
         cmp_q       <= '1;
         presc_q     <= '0;
         irq_q       <= 1'b0;
      end else begin
         rsp_valid_q <= accept;
         rsp_q       <= accept ? rsp_d : '0;
         mtime_q     <= mtime_d;
         cmp_q       <= cmp_d;
         presc_q     <= presc_d;
         irq_q       <= (mtime_d >= cmp_d);
      end
   end

   io_unit_serial_tx_fifo #(
      .DEPTH (SERIAL_FIFO_DEPTH),
      .WIDTH (8)
   ) u_serial_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  (ioReqWData[7:0]),
      .pop_i   (pop),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (serialData)
   );

   assign ioRspValid  = rsp_valid_q;
   assign ioRspRData  = rsp_q.rdata;
   assign ioRspError  = rsp_q.error;
   assign timerIrq    = irq_q;
   assign serialValid = !fifo_empty;

endmodule
